// File: rtl/spi_ram_arbiter.sv
// Shares one single-port RAM between an SPI command stream and a host port.
// SPI RAM commands wait in a one-entry buffer; ties alternate between requesters.
module spi_ram_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       host_req,
    input  logic       host_we,
    input  logic [7:0] host_addr,
    input  logic [7:0] host_wdata,
    output logic       host_gnt,
    output logic       host_rvalid,
    output logic [7:0] host_rdata,
    output logic       ram_en,
    output logic       ram_we,
    output logic [7:0] ram_addr,
    output logic [7:0] ram_wdata,
    input  logic [7:0] ram_rdata,
    output logic       spi_ovf
);

    typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT} state_t;
    typedef enum logic {GNT_SPI, GNT_HOST} who_t;

    state_t     state;
    who_t       last_gnt;
    logic [7:0] wr_addr, rd_addr;
    logic       pend_vld, pend_rd;
    logic [7:0] pend_addr, pend_data;
    logic       acc_spi, acc_rd;

    logic [1:0] op;
    logic [7:0] payload;
    logic       spi_cmd;
    logic       spi_win, host_win;

    assign op      = rx_data[9:8];
    assign payload = rx_data[7:0];
    assign spi_cmd = rx_valid && op[0];

    // SPI wins when it is alone or when the host had the previous grant.
    always_comb begin
        spi_win  = 1'b0;
        host_win = 1'b0;
        if (state == IDLE) begin
            if (pend_vld && (!host_req || last_gnt == GNT_HOST))
                spi_win = 1'b1;
            else if (host_req)
                host_win = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_gnt    <= GNT_HOST;
            wr_addr     <= '0;
            rd_addr     <= '0;
            pend_vld    <= 1'b0;
            pend_rd     <= 1'b0;
            pend_addr   <= '0;
            pend_data   <= '0;
            acc_spi     <= 1'b0;
            acc_rd      <= 1'b0;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            host_gnt    <= 1'b0;
            host_rvalid <= 1'b0;
            host_rdata  <= '0;
            ram_en      <= 1'b0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
            spi_ovf     <= 1'b0;
        end else begin
            ram_en      <= 1'b0;
            ram_we      <= 1'b0;
            host_gnt    <= 1'b0;
            tx_valid    <= 1'b0;
            host_rvalid <= 1'b0;

            if (rx_valid && op == 2'b00) wr_addr <= payload;
            if (rx_valid && op == 2'b10) rd_addr <= payload;

            // A grant frees the buffer in time to take a same-cycle command.
            if (spi_win) pend_vld <= 1'b0;
            if (spi_cmd) begin
                if (!pend_vld || spi_win) begin
                    pend_vld  <= 1'b1;
                    pend_rd   <= op[1];
                    pend_addr <= op[1] ? rd_addr : wr_addr;
                    pend_data <= payload;
                end else begin
                    spi_ovf <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (spi_win) begin
                        state     <= ISSUE;
                        last_gnt  <= GNT_SPI;
                        acc_spi   <= 1'b1;
                        acc_rd    <= pend_rd;
                        ram_en    <= 1'b1;
                        ram_we    <= !pend_rd;
                        ram_addr  <= pend_addr;
                        ram_wdata <= pend_data;
                    end else if (host_win) begin
                        state     <= ISSUE;
                        last_gnt  <= GNT_HOST;
                        acc_spi   <= 1'b0;
                        acc_rd    <= !host_we;
                        ram_en    <= 1'b1;
                        ram_we    <= host_we;
                        ram_addr  <= host_addr;
                        ram_wdata <= host_wdata;
                        host_gnt  <= 1'b1;
                    end
                end
                ISSUE: state <= acc_rd ? RD_WAIT : IDLE;
                RD_WAIT: begin
                    state <= IDLE;
                    if (acc_spi) begin
                        tx_data  <= ram_rdata;
                        tx_valid <= 1'b1;
                    end else begin
                        host_rdata  <= ram_rdata;
                        host_rvalid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Scoreboard bench: stimulus queues expected RAM accesses; a negedge monitor
// checks the RAM port, response pulses, latency, grant order and overflow.
module tb_spi_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       host_req = 1'b0, host_we = 1'b0;
    logic [7:0] host_addr = '0, host_wdata = '0;
    logic       host_gnt, host_rvalid;
    logic [7:0] host_rdata;
    logic       ram_en, ram_we;
    logic [7:0] ram_addr, ram_wdata, ram_rdata;
    logic       spi_ovf;

    spi_ram_arbiter dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .host_req(host_req),
        .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .spi_ovf(spi_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {logic we; logic [7:0] addr; logic [7:0] data; int exp_cyc;} acc_t;
    typedef struct {logic spi; logic [7:0] data; int due;} rsp_t;

    acc_t sq[$];
    acc_t hq[$];
    rsp_t rq[$];
    bit   glog[$];
    logic [7:0] refmem [256];
    logic [7:0] mem [256];
    logic [7:0] wr_a = '0, rd_a = '0;
    int cyc = 0;
    int ovf_cyc = -1;
    int checks = 0, failures = 0;

    function automatic logic [7:0] init_val(input int i);
        return 8'((i * 37) ^ 8'h5a);
    endfunction

    // RAM with one-cycle read latency
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = init_val(i);
        ram_rdata = '0;
        forever begin
            @(posedge clk);
            if (ram_en) begin
                if (ram_we) mem[ram_addr] <= ram_wdata;
                else        ram_rdata <= mem[ram_addr];
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor
    initial begin
        acc_t a;
        rsp_t r;
        bit prev_en, prev_tx, prev_hr, have;
        prev_en = 0; prev_tx = 0; prev_hr = 0;
        for (int i = 0; i < 256; i++) refmem[i] = init_val(i);
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_en = 0; prev_tx = 0; prev_hr = 0;
            end else begin
                if (!ram_en) chk("ram_we_idle", 32'(ram_we), 32'd0);
                if (ram_en) begin
                    chk("ram_en_spacing", 32'(prev_en), 32'd0);
                    have = 0;
                    if (host_gnt) begin
                        if (hq.size() == 0) fail_now("unexpected_host_access");
                        else begin a = hq.pop_front(); have = 1; end
                    end else begin
                        if (sq.size() == 0) fail_now("unexpected_spi_access");
                        else begin a = sq.pop_front(); have = 1; end
                    end
                    if (have) begin
                        chk("ram_we", 32'(ram_we), 32'(a.we));
                        chk("ram_addr", 32'(ram_addr), 32'(a.addr));
                        if (a.we) chk("ram_wdata", 32'(ram_wdata), 32'(a.data));
                        if (a.exp_cyc >= 0) chk("issue_latency", cyc, a.exp_cyc);
                        if (a.we) refmem[a.addr] = a.data;
                        else begin
                            r.spi = !host_gnt; r.data = refmem[a.addr]; r.due = cyc + 2;
                            rq.push_back(r);
                        end
                    end
                    glog.push_back(!host_gnt);
                end else if (host_gnt) fail_now("host_gnt_without_access");
                if (tx_valid && prev_tx) fail_now("tx_valid_not_pulse");
                if (host_rvalid && prev_hr) fail_now("host_rvalid_not_pulse");
                if (tx_valid || host_rvalid) begin
                    if (tx_valid && host_rvalid) fail_now("both_read_strobes");
                    if (rq.size() == 0) fail_now("unexpected_read_strobe");
                    else begin
                        r = rq.pop_front();
                        chk("rsp_source_spi", 32'(tx_valid), 32'(r.spi));
                        chk("rsp_data", 32'(tx_valid ? tx_data : host_rdata), 32'(r.data));
                        chk("rsp_latency", cyc, r.due);
                    end
                end else if (rq.size() > 0 && cyc > rq[0].due) begin
                    fail_now("read_strobe_missing");
                    void'(rq.pop_front());
                end
                chk("spi_ovf", 32'(spi_ovf), 32'(ovf_cyc >= 0 && cyc >= ovf_cyc));
                prev_en = ram_en; prev_tx = tx_valid; prev_hr = host_rvalid;
            end
        end
    end

    // Called at posedge+1; drives one strobe and returns at the next posedge+1.
    task automatic spi_strobe(input logic [1:0] op, input logic [7:0] pl, input bit accept, input int ecyc);
        acc_t a;
        rx_valid = 1'b1;
        rx_data  = {op, pl};
        if (op == 2'b00) wr_a = pl;
        if (op == 2'b10) rd_a = pl;
        if (op[0] && accept) begin
            a.we = !op[1]; a.addr = op[1] ? rd_a : wr_a; a.data = pl; a.exp_cyc = ecyc;
            sq.push_back(a);
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic host_start(input logic we, input logic [7:0] addr, input logic [7:0] data);
        acc_t a;
        host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = data;
        a.we = we; a.addr = addr; a.data = data; a.exp_cyc = -1;
        hq.push_back(a);
    endtask

    task automatic host_wait();
        bit got;
        got = 0;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            if (host_gnt) got = 1;
        end
        if (!got) fail_now("host_gnt_timeout");
        host_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            if (sq.size() == 0 && hq.size() == 0 && rq.size() == 0) done = 1;
            else begin @(posedge clk); #1; end
        end
        if (!done) fail_now("drain_timeout");
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; rx_valid = 1'b0; host_req = 1'b0;
        sq.delete(); hq.delete(); rq.delete();
        ovf_cyc = -1; wr_a = '0; rd_a = '0;
        @(posedge clk); #1;
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_host_gnt", 32'(host_gnt), 32'd0);
        chk("rst_host_rvalid", 32'(host_rvalid), 32'd0);
        chk("rst_host_rdata", 32'(host_rdata), 32'd0);
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        chk("rst_spi_ovf", 32'(spi_ovf), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        acc_t a;
        int n, sent;
        bit seen;
        @(posedge clk); #1;
        do_reset();

        // SPI write 0xA5 to 0x05
        spi_strobe(2'b00, 8'h05, 1, -1);
        spi_strobe(2'b01, 8'hA5, 1, cyc + 2);
        drain();

        // SPI read back from 0x05
        spi_strobe(2'b10, 8'h05, 1, -1);
        spi_strobe(2'b11, 8'h00, 1, cyc + 2);
        drain();

        // Tie right after reset: SPI first, then host read
        do_reset();
        glog.delete();
        spi_strobe(2'b00, 8'h12, 1, -1);
        spi_strobe(2'b01, 8'hCC, 1, cyc + 2);
        host_start(1'b0, 8'h10, 8'h00);
        host_wait();
        drain();
        chk("tie_grants", 32'(glog.size()), 32'd2);
        if (glog.size() == 2) begin
            chk("tie_first_spi", 32'(glog[0]), 32'd1);
            chk("tie_second_host", 32'(glog[1]), 32'd0);
        end

        // Both requesters kept busy: grants must alternate
        do_reset();
        glog.delete();
        spi_strobe(2'b00, 8'h30, 1, -1);
        spi_strobe(2'b01, 8'h11, 1, -1);
        host_start(1'b1, 8'h40, 8'h77);
        n = 0; sent = 1;
        for (int t = 0; t < 60 && n < 6; t++) begin
            @(negedge clk);
            rx_valid = 1'b0;
            if (ram_en) begin
                n++;
                if (host_gnt) begin
                    if (n < 6) begin
                        a.we = 1'b1; a.addr = 8'h40; a.data = 8'h77; a.exp_cyc = -1;
                        hq.push_back(a);
                    end else host_req = 1'b0;
                end else if (sent < 3) begin
                    rx_valid = 1'b1;
                    rx_data = {2'b01, 8'(8'h11 + sent)};
                    a.we = 1'b1; a.addr = wr_a; a.data = 8'(8'h11 + sent); a.exp_cyc = -1;
                    sq.push_back(a);
                    sent++;
                end
            end
        end
        host_req = 1'b0;
        @(posedge clk); #1;
        drain();
        chk("rr_grants", 32'(glog.size()), 32'd6);
        for (int i = 0; i < 6 && i < glog.size(); i++)
            chk("rr_order", 32'(glog[i]), 32'((i % 2) == 0));

        // Overflow: second SPI write while host read holds the RAM
        spi_strobe(2'b00, 8'h22, 1, -1);
        host_start(1'b0, 8'h21, 8'h00);
        seen = 0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (host_gnt) seen = 1;
        end
        if (!seen) fail_now("ovf_host_gnt_timeout");
        host_req = 1'b0;
        rx_valid = 1'b1; rx_data = {2'b01, 8'h5C};
        a.we = 1'b1; a.addr = wr_a; a.data = 8'h5C; a.exp_cyc = -1;
        sq.push_back(a);
        @(negedge clk);
        rx_data = {2'b01, 8'hC3};
        ovf_cyc = cyc + 1;
        @(negedge clk);
        rx_valid = 1'b0;
        @(posedge clk); #1;
        drain();
        chk("ovf_sticky", 32'(spi_ovf), 32'd1);
        chk("ovf_first_write_kept", 32'(mem[8'h22]), 32'h5C);

        // Reset during RD_WAIT of an SPI read discards the response
        do_reset();
        spi_strobe(2'b10, 8'h22, 1, -1);
        spi_strobe(2'b11, 8'h00, 1, -1);
        seen = 0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (ram_en) seen = 1;
        end
        if (!seen) fail_now("rdwait_issue_timeout");
        @(posedge clk); #1;
        do_reset();
        repeat (4) begin @(posedge clk); #1; end

        // Random traffic on a small address range
        fork
            begin
                int unsigned r;
                for (int i = 0; i < 500; i++) begin
                    r = $urandom_range(0, 9);
                    if (r < 2) spi_strobe(2'b00, 8'($urandom_range(0, 15)), 1, -1);
                    else if (r < 4) spi_strobe(2'b10, 8'($urandom_range(0, 15)), 1, -1);
                    else if (r < 8 && sq.size() == 0)
                        spi_strobe(r[0] ? 2'b01 : 2'b11, 8'($urandom), 1, -1);
                    else begin @(posedge clk); #1; end
                end
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
                    host_start(1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom));
                    host_wait();
                end
            end
        join
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_ram_arbiter.md
SPI_RAM_ARBITER -- requirements
Module: spi_ram_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  clock (rising edge); rst_n  in  1  reset, synchronous, active-low.
REQ-002 SHALL have ports: rx_data  in  10  SPI command word ([9:8] opcode, [7:0] payload); rx_valid  in  1  one-cycle strobe qualifying rx_data.
REQ-003 SHALL have ports: tx_data  out  8  read data to SPI slave; tx_valid  out  1  one-cycle strobe qualifying tx_data.
REQ-004 SHALL have ports: host_req  in  1; host_we  in  1; host_addr  in  8; host_wdata  in  8; host_gnt  out  1; host_rvalid  out  1; host_rdata  out  8.
REQ-005 SHALL have ports: ram_en  out  1; ram_we  out  1; ram_addr  out  8; ram_wdata  out  8; ram_rdata  in  8 (valid one cycle after a read issue); spi_ovf  out  1  sticky overflow.

Function
REQ-006 SHALL decode each rx_valid opcode: 00 load wr_addr; 01 write payload to RAM at wr_addr; 10 load rd_addr; 11 read RAM at rd_addr.
REQ-007 SHALL execute opcodes 00/10 in the cycle after the strobe, with no RAM access and no arbitration.
REQ-008 SHALL capture opcodes 01/11 into a one-entry SPI pending buffer: type, address (current wr_addr/rd_addr), and data.
REQ-009 SHALL assert spi_ovf (sticky until reset) on an 01/11 strobe while pending is set and not granted that cycle; the new command is dropped and the pending one kept.
REQ-010 SHALL clear the pending buffer in the grant cycle; an 01/11 strobe in that same cycle is accepted without overflow.
REQ-011 SHALL treat host as requesting while host_req=1; host_we/addr/wdata held stable until host_gnt.
REQ-012 SHALL use FSM states IDLE, ISSUE, RD_WAIT.
REQ-013 IDLE: only one requester pending -> grant it; both pending -> grant the one not granted last (round-robin); neither -> stay IDLE.
REQ-014 SHALL record the last-granted requester at each grant; reset value = HOST, so SPI wins the first tie.
REQ-015 ISSUE (one cycle): ram_en=1; ram_we/addr/wdata from the winner; host_gnt=1 if host won; next state RD_WAIT for reads, IDLE for writes.
REQ-016 RD_WAIT (one cycle): capture ram_rdata. SPI read -> tx_data=ram_rdata, tx_valid=1 next cycle. Host read -> host_rdata=ram_rdata, host_rvalid=1 next cycle. Next state IDLE.
REQ-017 SHALL keep ram_en=0, ram_we=0 outside ISSUE; ram_addr/ram_wdata hold their last values.
REQ-018 Latency: request visible in IDLE -> ISSUE next cycle; read data strobe 2 cycles after ISSUE; at most one RAM access per 2 cycles (write) or 3 cycles (read).
REQ-019 SHALL drive tx_valid, host_gnt and host_rvalid as single-cycle pulses only.
REQ-020 Address registers SHALL be 8 bits with no auto-increment; wrap does not apply.

Reset
REQ-021 rst_n=0 at a clk edge SHALL force: state IDLE; pending clear; wr_addr=rd_addr=0; last grant HOST; tx_data=0, tx_valid=0; host_gnt=0, host_rvalid=0, host_rdata=0; ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0; spi_ovf=0.
REQ-022 Reset mid-operation (ISSUE or RD_WAIT) SHALL discard the access; no tx_valid or host_rvalid follows.

Verification
REQ-023 SPI rx 0x005, then 0x1A5, host idle -> ISSUE with ram_addr=0x05, ram_wdata=0xA5, ram_we=1; no tx_valid.
REQ-024 SPI rx 0x205, then 0x300; RAM returns 0xA5 -> tx_valid pulse with tx_data=0xA5 exactly 2 cycles after ISSUE.
REQ-025 host read addr 0x10 and SPI write pending in the same IDLE cycle after reset -> SPI granted first; host_gnt next ISSUE; host_rvalid with RAM data.
REQ-026 Both requesters held continuously -> grants alternate SPI, HOST, SPI, HOST.
REQ-027 Two 01 strobes on consecutive cycles while host holds the RAM -> spi_ovf=1; only the first write reaches RAM.
REQ-028 rst_n=0 in RD_WAIT of an SPI read -> no tx_valid; all outputs at reset values next cycle.
